// File: rtl/lcd_display_sequencer_pkg.sv
// Shared encodings for the LCD display sequencer: states, command words, init ROM.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_CLR_WAIT,
    ST_IDLE,
    ST_ADDR1,
    ST_CHARS,
    ST_ADDR2
  } state_t;

  localparam int          RS_BIT    = 9;
  localparam int          RW_BIT    = 8;
  localparam logic [9:0]  IDLE_WORD = 10'h100;
  localparam logic [7:0]  CMD_ADDR1 = 8'h80;
  localparam logic [7:0]  CMD_ADDR2 = 8'hC0;
  localparam logic [4:0]  INIT_LAST = 5'd5;

  // Instruction write: RS=0, RW=0
  function automatic logic [9:0] cmd_word(input logic [7:0] c);
    return {2'b00, c};
  endfunction

  // Data write: RS=1, RW=0
  function automatic logic [9:0] char_word(input logic [7:0] c);
    logic [9:0] w;
    w = {2'b00, c};
    w[RS_BIT] = 1'b1;
    w[RW_BIT] = 1'b0;
    return w;
  endfunction

  // Power-on sequence: 8-bit wakeup, switch to 4-bit, 2 lines, entry mode, display on, clear
  function automatic logic [9:0] init_word(input logic [4:0] i);
    logic [9:0] w;
    case (i)
      5'd0:    w = 10'h033;
      5'd1:    w = 10'h032;
      5'd2:    w = 10'h028;
      5'd3:    w = 10'h006;
      5'd4:    w = 10'h00C;
      default: w = 10'h001;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lcd_display_sequencer_if.sv
// User-side bus of the sequencer: buffer writes, refresh request and the command word stream.
interface lcd_display_sequencer_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       refresh;
  logic [9:0] lcd_data;
  logic       ready;
  logic       busy;
  logic       slot_tick;

  modport master (
    output wr_en, wr_addr, wr_char, refresh,
    input  lcd_data, ready, busy, slot_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_char, refresh,
    output lcd_data, ready, busy, slot_tick
  );
endinterface

// File: rtl/lcd_display_sequencer_text_buffer.sv
// 32x8 text buffer (2 lines x 16): one write port, combinational read, resets to spaces.
module lcd_text_buffer (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char
);

  logic [7:0] mem [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_char;
    end
  end

  assign rd_char = mem[rd_addr];

endmodule

// File: rtl/lcd_display_sequencer.sv
// Slot-paced command sequencer for the 4-bit LCD nibble engine: power-on init, then full rewrites.
// Optional LCD_AUTO_REFRESH_EN: any buffer write schedules a rewrite without a refresh pulse.
module lcd_display_sequencer
  import lcd_pkg::*;
#(
  parameter int SLOT_CYCLES = 2080,
  parameter int POWER_SLOTS = 361,
  parameter int CLEAR_SLOTS = 40
) (
  input logic                    clk,
  input logic                    reset,
  lcd_display_sequencer_if.slave bus
);

  localparam int CNT_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int WAIT_MAX = (POWER_SLOTS > CLEAR_SLOTS) ? POWER_SLOTS : CLEAR_SLOTS;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] POWER_LAST = WAIT_W'(POWER_SLOTS - 1);
  localparam logic [WAIT_W-1:0] CLEAR_LAST = WAIT_W'(CLEAR_SLOTS - 1);

  logic [CNT_W-1:0]  slot_cnt_reg;
  logic              slot_tick;
  state_t            state_reg, state_next;
  logic [4:0]        idx_reg, idx_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [9:0]        data_reg, data_next;
  logic              pending_reg, pending_next;
  logic              start, consume;
  logic [4:0]        char_idx;
  logic [7:0]        rd_char;

  assign slot_tick = (slot_cnt_reg == SLOT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         slot_cnt_reg <= '0;
    else if (slot_tick) slot_cnt_reg <= '0;
    else                slot_cnt_reg <= slot_cnt_reg + 1'b1;
  end

  lcd_text_buffer u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_char (bus.wr_char),
    .rd_addr (char_idx),
    .rd_char (rd_char)
  );

  // Index of the character loaded at the coming slot boundary
  always_comb begin
    case (state_reg)
      ST_ADDR1: char_idx = 5'd0;
      ST_ADDR2: char_idx = 5'd16;
      default:  char_idx = idx_reg + 5'd1;
    endcase
  end

`ifdef LCD_AUTO_REFRESH_EN
  logic dirty_reg, dirty_next;
  assign start      = pending_reg | dirty_reg;
  assign dirty_next = bus.wr_en | (dirty_reg & ~consume);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dirty_reg <= 1'b0;
    else        dirty_reg <= dirty_next;
  end
`else
  assign start = pending_reg;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wait_next  = wait_reg;
    data_next  = data_reg;
    consume    = 1'b0;
    if (slot_tick) begin
      case (state_reg)
        ST_PWR_WAIT: begin
          if (wait_reg == POWER_LAST) begin
            state_next = ST_INIT;
            idx_next   = 5'd0;
            data_next  = init_word(5'd0);
          end else begin
            wait_next = wait_reg + 1'b1;
          end
        end
        ST_INIT: begin
          if (idx_reg == INIT_LAST) begin
            state_next = ST_CLR_WAIT;
            wait_next  = '0;
            data_next  = IDLE_WORD;
          end else begin
            idx_next  = idx_reg + 5'd1;
            data_next = init_word(idx_reg + 5'd1);
          end
        end
        ST_CLR_WAIT: begin
          if (wait_reg == CLEAR_LAST) begin
            state_next = ST_IDLE;
            data_next  = IDLE_WORD;
          end else begin
            wait_next = wait_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (start) begin
            state_next = ST_ADDR1;
            data_next  = cmd_word(CMD_ADDR1);
            consume    = 1'b1;
          end
        end
        ST_ADDR1, ST_ADDR2: begin
          state_next = ST_CHARS;
          idx_next   = char_idx;
          data_next  = char_word(rd_char);
        end
        ST_CHARS: begin
          if (idx_reg == 5'd15) begin
            state_next = ST_ADDR2;
            data_next  = cmd_word(CMD_ADDR2);
          end else if (idx_reg == 5'd31) begin
            state_next = ST_IDLE;
            idx_next   = 5'd0;
            data_next  = IDLE_WORD;
          end else begin
            idx_next  = char_idx;
            data_next = char_word(rd_char);
          end
        end
        default: begin
          state_next = ST_PWR_WAIT;
          wait_next  = '0;
          data_next  = IDLE_WORD;
        end
      endcase
    end
    // A request on the consuming edge survives as one more rewrite
    pending_next = bus.refresh | (pending_reg & ~consume);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_PWR_WAIT;
      idx_reg     <= '0;
      wait_reg    <= '0;
      data_reg    <= IDLE_WORD;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      wait_reg    <= wait_next;
      data_reg    <= data_next;
      pending_reg <= pending_next;
    end
  end

  assign bus.lcd_data  = data_reg;
  assign bus.slot_tick = slot_tick;
  assign bus.busy      = (state_reg != ST_IDLE);
`ifdef LCD_AUTO_REFRESH_EN
  assign bus.ready     = (state_reg == ST_IDLE) && !pending_reg && !dirty_reg;
`else
  assign bus.ready     = (state_reg == ST_IDLE) && !pending_reg;
`endif

endmodule
